// File: rtl/current_sense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : current_sense_ctrl
// Purpose  : SPI sequencer for the motor current-sense ADC: command word, two
//            pipeline dummy frames, then per-channel scans (single or repeat).
//            Optional macro CS_CTRL_CH_CHECK_EN enables the channel-tag check.
// Revision : 1.0 - initial release
// ============================================================================
module current_sense_ctrl #(
    parameter int NUM_CH     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   repeat_mode,
    input  logic [NUM_CH-1:0]      ch_mask,
    output logic [15:0]            spi_master_do,
    output logic                   spi_master_start,
    input  logic                   spi_master_done,
    input  logic [15:0]            spi_master_di,
    output logic [12*NUM_CH-1:0]   sample_data,
    output logic [NUM_CH-1:0]      sample_valid,
    output logic                   scan_done,
    output logic                   id_err,
    output logic                   busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_cmd   = 3'd1;
    localparam logic [2:0] c_st_dummy = 3'd2;
    localparam logic [2:0] c_st_scan  = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [1:0] c_ph_issue = 2'd0;
    localparam logic [1:0] c_ph_wait  = 2'd1;
    localparam logic [1:0] c_ph_gap   = 2'd2;

    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]            r_state;
    logic [1:0]            r_phase;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_dummy;
    logic [CH_W-1:0]       r_ch;
    logic [NUM_CH-1:0]     r_mask;
    logic                  r_repeat;
    logic                  r_stop_pend;
    logic [15:0]           r_spi_do;
    logic                  r_spi_start;
    logic [12*NUM_CH-1:0]  r_sample;
    logic [NUM_CH-1:0]     r_valid;
    logic                  r_scan_done;

    logic [CH_W-1:0]       w_first_ch;
    logic [CH_W-1:0]       w_next_ch;
    logic                  w_has_next;
    logic [7:0]            w_mask8;
    logic [15:0]           w_cmd;
    logic [15:0]           w_frame_word;
    logic                  w_done_ok;
    logic                  w_stop_now;
    logic                  w_tag_ok;

    // Lowest enabled channel, and the next enabled channel above the current one
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_ch = CH_W'(i);
                if (CH_W'(i) > r_ch) begin
                    w_next_ch  = CH_W'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    // Mask is bit-reversed into the command: channel i lands on bit 13-i
    always_comb begin
        w_mask8 = 8'(r_mask);
        w_cmd   = {1'b1, r_repeat, 14'd0};
        for (int i = 0; i < 8; i++) begin
            w_cmd[13-i] = w_mask8[i];
        end
    end

    always_comb begin
        w_frame_word = 16'h0000;
        if (r_state == c_st_cmd) begin
            w_frame_word = w_cmd;
        end else if (r_state == c_st_halt) begin
            w_frame_word = 16'h8000;
        end
    end

    // A done coinciding with our own start strobe cannot belong to this frame
    assign w_done_ok  = (r_phase == c_ph_wait) && spi_master_done && !r_spi_start;
    assign w_stop_now = r_stop_pend | stop;

`ifdef CS_CTRL_CH_CHECK_EN
    logic r_id_err;
    assign w_tag_ok = (spi_master_di[15:12] == 4'(r_ch));
    assign id_err   = r_id_err;
`else
    logic w_unused_tag;
    assign w_unused_tag = &{1'b0, spi_master_di[15:12]};
    assign w_tag_ok     = 1'b1;
    assign id_err       = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_phase     <= c_ph_issue;
            r_gap       <= '0;
            r_dummy     <= 1'b0;
            r_ch        <= '0;
            r_mask      <= '0;
            r_repeat    <= 1'b0;
            r_stop_pend <= 1'b0;
            r_spi_do    <= '0;
            r_spi_start <= 1'b0;
            r_sample    <= '0;
            r_valid     <= '0;
            r_scan_done <= 1'b0;
`ifdef CS_CTRL_CH_CHECK_EN
            r_id_err    <= 1'b0;
`endif
        end else begin
            r_spi_start <= 1'b0;
            r_valid     <= '0;
            r_scan_done <= 1'b0;
`ifdef CS_CTRL_CH_CHECK_EN
            r_id_err    <= 1'b0;
`endif
            if ((r_state != c_st_idle) && stop) begin
                r_stop_pend <= 1'b1;
            end

            if (r_state == c_st_idle) begin
                if (start && (|ch_mask)) begin
                    r_mask      <= ch_mask;
                    r_repeat    <= repeat_mode;
                    r_stop_pend <= 1'b0;
                    r_phase     <= c_ph_issue;
                    r_state     <= c_st_cmd;
                end
            end else begin
                case (r_phase)
                    c_ph_issue: begin
                        r_spi_start <= 1'b1;
                        r_spi_do    <= w_frame_word;
                        r_phase     <= c_ph_wait;
                    end
                    c_ph_wait: begin
                        if (w_done_ok) begin
                            r_phase <= c_ph_gap;
                            r_gap   <= '0;
                            if (r_state == c_st_scan) begin
                                r_scan_done <= !w_has_next;
                                if (w_tag_ok) begin
                                    r_sample[12*int'(r_ch) +: 12] <= spi_master_di[11:0];
                                    r_valid[r_ch]                 <= 1'b1;
                                end
`ifdef CS_CTRL_CH_CHECK_EN
                                r_id_err <= !w_tag_ok;
`endif
                            end
                        end
                    end
                    c_ph_gap: begin
                        if (r_gap == c_gap_last) begin
                            r_phase <= c_ph_issue;
                            case (r_state)
                                c_st_cmd: begin
                                    r_dummy <= 1'b0;
                                    r_state <= w_stop_now ? c_st_halt : c_st_dummy;
                                end
                                c_st_dummy: begin
                                    if (w_stop_now) begin
                                        r_state <= c_st_halt;
                                    end else if (!r_dummy) begin
                                        r_dummy <= 1'b1;
                                    end else begin
                                        r_state <= c_st_scan;
                                        r_ch    <= w_first_ch;
                                    end
                                end
                                c_st_scan: begin
                                    r_ch <= w_has_next ? w_next_ch : w_first_ch;
                                    // A finished single scan has no next frame to replace
                                    if (!w_has_next && !r_repeat) begin
                                        r_state     <= c_st_idle;
                                        r_stop_pend <= 1'b0;
                                    end else if (w_stop_now) begin
                                        r_state <= c_st_halt;
                                    end
                                end
                                default: begin
                                    r_state     <= c_st_idle;
                                    r_stop_pend <= 1'b0;
                                end
                            endcase
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                    default: r_phase <= c_ph_issue;
                endcase
            end
        end
    end

    assign spi_master_do    = r_spi_do;
    assign spi_master_start = r_spi_start;
    assign sample_data      = r_sample;
    assign sample_valid     = r_valid;
    assign scan_done        = r_scan_done;
    assign busy             = (r_state != c_st_idle);

endmodule
`default_nettype wire
